// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : pc_sequencer
//  Function : PC-source decode, return-address stack and redirect-flush
//             sequencing for the instruction-fetch PC register.
//             Optional build macro PC_SEQ_RAS_CIRCULAR_EN turns the return
//             stack into a circular buffer: a call when full overwrites the
//             oldest entry, and the overflow flag pulses for one cycle
//             instead of halting.
//  Revision : 1.0  initial release
// ============================================================================
module pc_sequencer #(
    parameter int DEPTH = 8,
    parameter int AW    = 32
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [AW-1:0]              PC,
    input  logic                       sig_stall,
    input  logic                       sig_is_branch,
    input  logic                       sig_zero_flag,
    input  logic                       sig_is_jump,
    input  logic                       sig_is_call,
    input  logic                       sig_stop_bit,
    output logic [1:0]                 sig_pc_src,
    output logic                       sig_pc_write,
    output logic [AW-1:0]              ReturnAddress,
    output logic                       sig_flush,
    output logic                       sig_halt,
    output logic                       sig_stack_overflow,
    output logic                       sig_stack_underflow,
    output logic [$clog2(DEPTH+1)-1:0] sig_stack_depth
);

    localparam int c_PTR_W   = $clog2(DEPTH);
    localparam int c_DEPTH_W = $clog2(DEPTH + 1);

    localparam logic [1:0] c_SRC_DFT = 2'b00;
    localparam logic [1:0] c_SRC_RA  = 2'b01;
    localparam logic [1:0] c_SRC_BTA = 2'b10;
    localparam logic [1:0] c_SRC_JMP = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [c_DEPTH_W-1:0]   r_depth;
    logic [c_PTR_W-1:0]     r_wp;
    logic [AW-1:0]          r_stack [DEPTH];
    logic                   r_ovf;
    logic                   r_unf;

    logic                   w_push;
    logic                   w_pop;
    logic                   w_ovf_evt;
    logic                   w_unf_evt;
    logic [1:0]             w_src;
    logic                   w_write;
    logic                   w_flush;
    logic                   w_halt;
    logic                   w_full;
    logic                   w_empty;
    logic [c_PTR_W-1:0]     w_top_idx;
    logic [AW-1:0]          w_pc_plus4;

    // The write pointer wraps modulo DEPTH, so the top entry is always one
    // slot below it regardless of whether the circular mode has wrapped.
    assign w_full     = (r_depth == c_DEPTH_W'(DEPTH));
    assign w_empty    = (r_depth == '0);
    assign w_top_idx  = r_wp - 1'b1;
    assign w_pc_plus4 = PC + AW'(4);

    // Next-state and control decode; nothing is requested while reset is high.
    always_comb begin
        w_next_state = r_state;
        w_push       = 1'b0;
        w_pop        = 1'b0;
        w_ovf_evt    = 1'b0;
        w_unf_evt    = 1'b0;
        w_src        = c_SRC_DFT;
        w_write      = 1'b0;
        w_flush      = 1'b0;
        w_halt       = 1'b0;
        if (!reset) begin
            case (r_state)
                ST_RUN: begin
                    if (!sig_stall) begin
                        w_write = 1'b1;
                        if (sig_stop_bit) begin
                            if (w_empty) begin
                                w_write      = 1'b0;
                                w_unf_evt    = 1'b1;
                                w_next_state = ST_HALT;
                            end else begin
                                w_src        = c_SRC_RA;
                                w_pop        = 1'b1;
                                w_next_state = ST_FLUSH;
                            end
                        end else if (sig_is_call) begin
                            w_src = c_SRC_JMP;
                            if (w_full) begin
                                w_ovf_evt = 1'b1;
`ifdef PC_SEQ_RAS_CIRCULAR_EN
                                w_push       = 1'b1;
                                w_next_state = ST_FLUSH;
`else
                                w_next_state = ST_HALT;
`endif
                            end else begin
                                w_push       = 1'b1;
                                w_next_state = ST_FLUSH;
                            end
                        end else if (sig_is_jump) begin
                            w_src        = c_SRC_JMP;
                            w_next_state = ST_FLUSH;
                        end else if (sig_is_branch && sig_zero_flag) begin
                            w_src        = c_SRC_BTA;
                            w_next_state = ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    // The bubble holds through stalls until a real cycle passes.
                    w_flush = 1'b1;
                    if (!sig_stall) begin
                        w_write      = 1'b1;
                        w_next_state = ST_RUN;
                    end
                end
                ST_HALT: begin
                    w_flush = 1'b1;
                    w_halt  = 1'b1;
                end
                default: begin
                    w_next_state = ST_RUN;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Stack bookkeeping: depth saturates on a circular overwrite, pointer wraps.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_depth <= '0;
            r_wp    <= '0;
        end else if (w_push) begin
            r_wp <= r_wp + 1'b1;
            if (!w_full) begin
                r_depth <= r_depth + 1'b1;
            end
        end else if (w_pop) begin
            r_wp    <= r_wp - 1'b1;
            r_depth <= r_depth - 1'b1;
        end
    end

    // Stack storage is not reset; entries are hidden while depth is zero.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_stack[r_wp] <= w_pc_plus4;
        end
    end

    // Error flags: underflow is sticky; overflow is sticky unless circular.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
`ifdef PC_SEQ_RAS_CIRCULAR_EN
            r_ovf <= w_ovf_evt;
`else
            r_ovf <= r_ovf | w_ovf_evt;
`endif
            r_unf <= r_unf | w_unf_evt;
        end
    end

    assign sig_pc_src          = w_src;
    assign sig_pc_write        = w_write;
    assign sig_flush           = w_flush;
    assign sig_halt            = w_halt;
    assign ReturnAddress       = (reset || w_empty) ? '0 : r_stack[w_top_idx];
    assign sig_stack_overflow  = reset ? 1'b0 : r_ovf;
    assign sig_stack_underflow = reset ? 1'b0 : r_unf;
    assign sig_stack_depth     = reset ? '0 : r_depth;

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
# pc_sequencer

Control block for the instruction-fetch PC register. Each cycle it decodes the fetch/decode control flags (branch, jump, call, stop bit, zero flag, stall) into the 2-bit `sig_pc_src` select and a PC write enable. It owns the return-address stack that supplies `ReturnAddress`, and inserts a one-cycle flush bubble after every taken redirect. It sits between the decode/control unit and the PC register, so the PC register itself stays a pure mux-plus-register.

## Interface
Parameters:
- `DEPTH`, 8: return-stack entries (power of 2, ≥2).
- `AW`, 32: address width.

Ports:
- `clock` in 1: single clock; all state changes on posedge.
- `reset` in 1: synchronous, active-high.
- `PC` in AW: current PC value, read back from the PC register.
- `sig_stall` in 1: freeze fetch this cycle.
- `sig_is_branch` in 1: decoded instruction is BEQ.
- `sig_zero_flag` in 1: ALU zero result for the branch compare.
- `sig_is_jump` in 1: J-type J.
- `sig_is_call` in 1: J-type JAL.
- `sig_stop_bit` in 1: return request; pops the stack.
- `sig_pc_src` out 2: 00 Dft (PC+4), 01 Ra, 10 BTA, 11 Jmp.
- `sig_pc_write` out 1: PC register load enable.
- `ReturnAddress` out AW: top of stack, combinational.
- `sig_flush` out 1: kill the wrong-path instruction in decode.
- `sig_halt` out 1: sequencer is in HALT.
- `sig_stack_overflow` out 1: sticky overflow flag.
- `sig_stack_underflow` out 1: sticky underflow flag.
- `sig_stack_depth` out $clog2(DEPTH+1): current entry count.

## Operation
States:
- RUN: normal decode.
- FLUSH: bubble after a redirect.
- HALT: terminal error state, exits only on reset.

Priority in RUN when not stalled:
- First, `sig_stop_bit`: src=Ra, pop.
- Else `sig_is_call`: src=Jmp, push PC+4.
- Else `sig_is_jump`: src=Jmp.
- Else `sig_is_branch & sig_zero_flag`: src=BTA.
- Else src=Dft.

Redirects:
- Any src≠Dft in RUN is a redirect; the next state is FLUSH.
- FLUSH: `sig_flush`=1, src=Dft, `sig_pc_write`=1, all control inputs ignored, no stack change. FLUSH returns to RUN after one cycle.

Stall:
- `sig_stall`=1 in RUN or FLUSH: `sig_pc_write`=0, src=Dft, and no state or stack change. FLUSH persists until a non-stalled cycle.

Stack:
- `ReturnAddress` = entry[depth-1] when depth>0, otherwise 0.
- Push writes PC+4 (modulo 2^AW) at index depth.
- Pop decrements depth.
- The pop value is presented in the same cycle the PC register samples it.

Errors:
- Overflow: a call with depth==DEPTH performs no push, sets `sig_stack_overflow`, and goes to HALT.
- Underflow: a return with depth==0 sets `sig_stack_underflow`, forces src=Dft and `sig_pc_write`=0, and goes to HALT.
- HALT: `sig_pc_write`=0, src=Dft, `sig_flush`=1, `sig_halt`=1; only reset exits.

Simultaneous flags follow the priority list, so a call together with the stop bit is a return only.

## Timing
- Outputs in RUN are combinational from the inputs and state. State, depth and stack entries update at the posedge that the PC register samples.
- Redirect latency is zero: target loaded at the edge ending the decode cycle. `sig_flush` is high for exactly the next non-stalled cycle.
- Reset values while `reset`=1:
  - State RUN, depth 0, all flags 0.
  - `sig_flush`=0, `sig_halt`=0, `sig_pc_write`=0.
  - src=Dft, `ReturnAddress`=0.
- Stack entries are not cleared by reset; they are unreadable at depth 0.
- Reset mid-FLUSH or in HALT returns to RUN on the next edge.
- First fetch enable is the cycle after `reset` deasserts.

## Configuration
- `PC_SEQ_RAS_CIRCULAR_EN` defined:
  - Stack is a circular buffer; a call at depth==DEPTH overwrites the oldest entry.
  - Depth saturates at DEPTH; the push and redirect proceed normally.
  - `sig_stack_overflow` pulses for 1 cycle (not sticky) with no HALT.
  - Underflow behaviour is unchanged.
- Undefined: overflow behaves as specified above (sticky flag, HALT).

## Test plan
- Reset, then 4 plain cycles at PC=0,4,8,12 with no flags → src=00, `sig_pc_write`=1, `sig_flush`=0 throughout.
- Branch at PC=0x10 with zero=1 → src=10 that cycle, `sig_flush`=1 next cycle. Same branch with zero=0 → src=00, no flush.
- JAL at PC=0x20, then stop bit 3 cycles later → depth 1 with entry 0x24. On return, `ReturnAddress`=0x24, src=01, depth returns to 0, flush follows.
- Nested calls to DEPTH=8 then a 9th call → `sig_stack_overflow`=1, `sig_halt`=1, `sig_pc_write`=0 until reset. With the macro: no halt, oldest entry dropped, 8 returns yield the last 8 pushed addresses.
- Stop bit at depth 0 → `sig_stack_underflow`=1, HALT. Assert `reset` for 1 cycle → all flags 0, depth 0, RUN.
- Stall asserted during a FLUSH cycle → `sig_pc_write`=0, `sig_flush` stays 1 until the first non-stalled cycle. Call together with stop bit → treated as return only.
